pe_acc: RTL
===========

PE_ACC -- requirements
Module: pe_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the signed operand width.
REQ-002 Parameter ACC_WIDTH, default 32, SHALL set the signed accumulator and result width; it SHALL be at least 2*DATA_WIDTH.
REQ-003 Parameter SAT_EN, default 1, SHALL select saturating (1) or wrapping (0) accumulation.
REQ-004 Port list, one port per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_in  in  DATA_WIDTH  signed activation.
- w_in  in  DATA_WIDTH  signed weight.
- vld_in  in  1  operand pair valid.
- last_in  in  1  marks the final operand pair of a tile; qualified by vld_in.
- i_out, w_out  out  DATA_WIDTH  registered pass-through of i_in and w_in.
- vld_out, last_out  out  1  registered pass-through of vld_in and last_in.
- res_in  in  ACC_WIDTH  result from the upstream PE on the drain chain.
- res_vld_in  in  1  res_in valid.
- res_out  out  ACC_WIDTH  registered drain-chain output.
- res_vld_out  out  1  res_out valid.
- drain_tok_in  in  1  drain token from the downstream PE or controller.
- drain_tok_out  out  1  drain token to the upstream PE.
- ovf  out  1  sticky saturation/overflow flag.
- err  out  1  sticky flag for result-buffer overwrite or drain collision.

Function
REQ-005 i_out, w_out, vld_out and last_out SHALL equal the inputs delayed by exactly 1 cycle, including when vld_in=0.
REQ-006 The accumulator SHALL update only when vld_in=1; zero-valued operands with vld_in=1 SHALL still count as MAC operations.
REQ-007 The product SHALL be the full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH before addition.
REQ-008 With SAT_EN=1, a sum outside the ACC_WIDTH signed range SHALL clamp to the maximum or minimum value and set ovf; with SAT_EN=0, the sum SHALL wrap and ovf SHALL set on signed overflow.
REQ-009 On vld_in=1 and last_in=1, the buffer SHALL load acc+product (saturated per REQ-008) and the accumulator SHALL become 0 in the same edge, so the next tile starts with no bubble.
REQ-010 FSM states SHALL be IDLE, ACC and HOLD.
- IDLE -> ACC on a valid non-last operand.
- IDLE/ACC -> HOLD on a valid last operand.
- HOLD -> ACC or IDLE when the buffer is emitted, selected by whether the accumulator is mid-tile.
- Accumulation SHALL continue while in HOLD.
REQ-011 If a valid last operand arrives while the buffer is full and not being emitted that cycle, the buffer SHALL be overwritten with the new result and err SHALL set.
REQ-012 If drain_tok_in=1 and the buffer is full:
- next cycle res_out=buffer, res_vld_out=1, drain_tok_out=1;
- the buffer SHALL empty.
REQ-013 If drain_tok_in=1 and the buffer is empty, next cycle drain_tok_out=1 and nothing is emitted.
REQ-014 Otherwise res_out and res_vld_out SHALL equal res_in and res_vld_in delayed by 1 cycle, and drain_tok_out=0.
REQ-015 If res_vld_in=1 coincides with an own emission, the own result SHALL win, res_in SHALL be dropped, and err SHALL set.
REQ-016 A buffer load and an emission in the same cycle SHALL emit the old value and retain the new one.

Reset
REQ-017 rst_n low SHALL asynchronously clear:
- all outputs, the accumulator, the buffer, ovf and err to 0;
- the FSM to IDLE.
REQ-018 Reset asserted mid-tile or mid-drain SHALL discard all partial results; the first edge after release SHALL behave as from IDLE.
REQ-019 ovf and err SHALL clear only on reset.

Structure
REQ-020 Package pe_pkg SHALL hold the FSM state typedef and the saturation max/min constant functions of width.
REQ-021 Saturating addition SHALL be a sub-module sat_add (parameters WIDTH and SAT_EN; outputs sum and ovf), instantiated once.

Verification (DATA_WIDTH=8, ACC_WIDTH=20 unless stated)
REQ-022 Reset mid-stream -> all outputs 0 immediately; after release, pairs (2,3) last -> buffer 6.
REQ-023 Pairs (3,4), (-2,5), (7,7), (1,-1) with last on the 4th, then drain_tok_in pulse -> res_out=50, res_vld_out=1 and drain_tok_out=1 one cycle after the token.
REQ-024 ACC_WIDTH=16, SAT_EN=1, three pairs (127,127) -> result 32767, ovf=1; with SAT_EN=0 -> result -17149, ovf=1.
REQ-025 vld_in=0 with (3,3), then (0,5) valid, then (2,2) valid last -> result 4; pass-through outputs track with 1-cycle delay.
REQ-026 res_vld_in=1 with res_in=0x00123 and no token -> res_out=0x00123 next cycle; the same input coinciding with own emission -> own result out, err=1.
REQ-027 Two tiles completing with no token (results 6 then 9) -> err=1; a subsequent token -> res_out=9.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg -- shared FSM state type and signed saturation limits. Rev 1.0
`default_nettype none

package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } pe_state_e;

  // Limits are returned in 64 bits; callers keep the low `width` bits.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_add.sv
// sat_add -- signed adder with optional clamp to the WIDTH-bit range. Rev 1.0
`default_nettype none

module sat_add
  import pe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  localparam logic [63:0]      c_max64 = sat_max(WIDTH);
  localparam logic [63:0]      c_min64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] c_max   = c_max64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_min   = c_min64[WIDTH-1:0];

  logic [WIDTH:0] full;

  // One guard bit: overflow whenever it disagrees with the result sign.
  assign full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign ovf  = full[WIDTH] ^ full[WIDTH-1];

  generate
    if (SAT_EN) begin : g_sat
      assign sum = ovf ? (full[WIDTH] ? c_min : c_max) : full[WIDTH-1:0];
    end else begin : g_wrap
      assign sum = full[WIDTH-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pe_acc.sv
// pe_acc -- MAC processing element with result buffer and drain-token chain. Rev 1.0
`default_nettype none

module pe_acc
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic                         vld_in,
  input  logic                         last_in,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] w_out,
  output logic                         vld_out,
  output logic                         last_out,
  input  logic signed [ACC_WIDTH-1:0]  res_in,
  input  logic                         res_vld_in,
  output logic signed [ACC_WIDTH-1:0]  res_out,
  output logic                         res_vld_out,
  input  logic                         drain_tok_in,
  output logic                         drain_tok_out,
  output logic                         ovf,
  output logic                         err
);

  pe_state_e                     state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, buf_q, buf_d;
  logic                          mid_q, mid_d;
  logic signed [ACC_WIDTH-1:0]   res_d;
  logic                          res_vld_d, tok_d, ovf_d, err_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext, sum;
  logic                          add_ovf, emit, load, full_d;

  assign prod     = (2*DATA_WIDTH)'(i_in) * (2*DATA_WIDTH)'(w_in);
  assign prod_ext = ACC_WIDTH'(prod);

  sat_add #(
    .WIDTH  (ACC_WIDTH),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_comb begin
    emit  = drain_tok_in && (state_q == HOLD);
    load  = vld_in && last_in;
    acc_d = acc_q;
    buf_d = buf_q;
    mid_d = mid_q;
    if (vld_in) begin
      if (last_in) begin
        acc_d = '0;
        buf_d = sum;
        mid_d = 1'b0;
      end else begin
        acc_d = sum;
        mid_d = 1'b1;
      end
    end
    // A load in the emitting cycle keeps the buffer full with the new value.
    full_d  = load || ((state_q == HOLD) && !emit);
    state_d = full_d ? HOLD : (mid_d ? ACC : IDLE);
    ovf_d   = ovf || (vld_in && add_ovf);
    err_d   = err || (load && (state_q == HOLD) && !emit) || (emit && res_vld_in);
    if (drain_tok_in) begin
      tok_d     = 1'b1;
      res_vld_d = emit;
      res_d     = emit ? buf_q : '0;
    end else begin
      tok_d     = 1'b0;
      res_vld_d = res_vld_in;
      res_d     = res_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      buf_q         <= '0;
      mid_q         <= 1'b0;
      i_out         <= '0;
      w_out         <= '0;
      vld_out       <= 1'b0;
      last_out      <= 1'b0;
      res_out       <= '0;
      res_vld_out   <= 1'b0;
      drain_tok_out <= 1'b0;
      ovf           <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      buf_q         <= buf_d;
      mid_q         <= mid_d;
      i_out         <= i_in;
      w_out         <= w_in;
      vld_out       <= vld_in;
      last_out      <= last_in;
      res_out       <= res_d;
      res_vld_out   <= res_vld_d;
      drain_tok_out <= tok_d;
      ovf           <= ovf_d;
      err           <= err_d;
    end
  end

endmodule

`default_nettype wire
